// File: rtl/nes_ppu_pkg.sv
// Shared types and helpers for the PPU background attribute fetch path.
// Used by attr_fetch_ctrl and its palette FIFO.
package nes_ppu_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} attr_state_t;

   localparam int ATTR_ROM_AW = 7;
   localparam int TILE_COL_W  = 5;
   localparam int TILE_ROW_W  = 5;

   // Each attribute byte covers a 4x4 tile block; the 2x2 quadrant picks the bit pair.
   function automatic logic [1:0] attr_quad(input logic [7:0] attr_byte,
                                            input logic       row1,
                                            input logic       col1);
      logic [1:0] quad;
      case ({row1, col1})
         2'b00:   quad = attr_byte[1:0];
         2'b01:   quad = attr_byte[3:2];
         2'b10:   quad = attr_byte[5:4];
         default: quad = attr_byte[7:6];
      endcase
      return quad;
   endfunction

endpackage

// File: rtl/attr_pal_fifo.sv
// Synchronous palette FIFO with occupancy count; head data is read combinationally.
// Push when full and pop when empty are both ignored.
module attr_pal_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [W-1:0]     push_data_i,
   input  logic             pop_i,
   output logic [W-1:0]     head_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             pop_ok;
   logic             push_ok;

   assign pop_ok  = pop_i && (count_q != '0);
   assign push_ok = push_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
         else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/attr_fetch_ctrl.sv
// Attribute-table fetch sequencer for one background scanline, feeding a palette FIFO.
// Optional ATTR_CACHE_EN keeps the last ROM byte so repeat addresses skip the ROM wait.
module attr_fetch_ctrl
   import nes_ppu_pkg::*;
#(
   parameter int TILES_PER_LINE = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int ADDR_W         = ATTR_ROM_AW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  line_start,
   input  logic [TILE_ROW_W-1:0] tile_row,
   input  logic                  nt_sel,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [7:0]            rom_dout,
   output logic [1:0]            pal_data,
   output logic                  pal_valid,
   input  logic                  pal_ready,
   output logic                  busy,
   output logic                  line_done,
   output attr_state_t           state_dbg
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   attr_state_t           state_q;
   logic [TILE_COL_W-1:0] col_q;
   logic [TILE_COL_W-1:0] col_nx;
   logic [4:1]            row_q;
   logic                  nt_q;
   logic [ADDR_W-1:0]     rom_addr_q;
   logic                  line_done_q;

   logic [CNT_W-1:0]      fifo_cnt;
   logic                  space;
   logic                  last_col;
   logic                  hit_push;
   logic                  push_en;
   logic [1:0]            push_data;
   logic                  row_lsb_unused;

   // Only the quadrant and block bits of the row matter for attributes.
   assign row_lsb_unused = tile_row[0];

   assign space    = fifo_cnt < CNT_W'(FIFO_DEPTH);
   assign last_col = col_q == TILE_COL_W'(TILES_PER_LINE - 1);
   assign col_nx   = col_q + TILE_COL_W'(1);

`ifdef ATTR_CACHE_EN
   logic              cache_vld_q;
   logic [ADDR_W-1:0] cache_tag_q;
   logic [7:0]        cache_byte_q;

   assign hit_push = (state_q == ISSUE) && cache_vld_q && (cache_tag_q == rom_addr_q) && space;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_vld_q  <= 1'b0;
         cache_tag_q  <= '0;
         cache_byte_q <= '0;
      end else if (state_q == IDLE && line_start) begin
         cache_vld_q <= 1'b0;
      end else if (state_q == WAIT) begin
         cache_vld_q  <= 1'b1;
         cache_tag_q  <= rom_addr_q;
         cache_byte_q <= rom_dout;
      end
   end
`else
   assign hit_push = 1'b0;
`endif

   // A tile completes either on its ROM-wait cycle or on a cache hit in ISSUE.
   always_comb begin
      push_en   = 1'b0;
      push_data = 2'b00;
      if (state_q == WAIT) begin
         push_en   = 1'b1;
         push_data = attr_quad(rom_dout, row_q[1], col_q[1]);
      end
`ifdef ATTR_CACHE_EN
      else if (hit_push) begin
         push_en   = 1'b1;
         push_data = attr_quad(cache_byte_q, row_q[1], col_q[1]);
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         nt_q        <= 1'b0;
         rom_addr_q  <= '0;
         line_done_q <= 1'b0;
      end else begin
         line_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (line_start) begin
                  row_q      <= tile_row[4:1];
                  nt_q       <= nt_sel;
                  col_q      <= '0;
                  rom_addr_q <= ADDR_W'({nt_sel, tile_row[4:2], 3'b000});
                  state_q    <= ISSUE;
               end
            end
            ISSUE, WAIT: begin
               if (push_en) begin
                  if (last_col) begin
                     state_q     <= DONE;
                     line_done_q <= 1'b1;
                  end else begin
                     col_q      <= col_nx;
                     rom_addr_q <= ADDR_W'({nt_q, row_q[4:2], col_nx[4:2]});
                     state_q    <= ISSUE;
                  end
               end else if (space) begin
                  state_q <= WAIT;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   attr_pal_fifo #(
      .W     (2),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_en),
      .push_data_i (push_data),
      .pop_i       (pal_ready),
      .head_o      (pal_data),
      .count_o     (fifo_cnt)
   );

   assign rom_addr  = rom_addr_q;
   assign pal_valid = fifo_cnt != '0;
   assign busy      = state_q != IDLE;
   assign line_done = line_done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_attr_fetch_ctrl.sv
// Directed bench for attr_fetch_ctrl: ROM model, palette scoreboard, timing checks.
// Build with ATTR_CACHE_EN defined to exercise the cached variant.
module tb_attr_fetch_ctrl;
  import nes_ppu_pkg::*;

`ifdef ATTR_CACHE_EN
  localparam int LAT_LO = 38;
  localparam int LAT_HI = 42;
  localparam int READS_PER_LINE = 8;
  localparam int STALL_READS = 1;
  localparam int POPS_BEFORE_RST = 16;
`else
  localparam int LAT_LO = 64;
  localparam int LAT_HI = 66;
  localparam int READS_PER_LINE = 32;
  localparam int STALL_READS = 4;
  localparam int POPS_BEFORE_RST = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [4:0]  tile_row;
  logic        nt_sel;
  logic [6:0]  rom_addr;
  logic [7:0]  rom_dout = 8'h00;
  logic [1:0]  pal_data;
  logic        pal_valid;
  logic        pal_ready;
  logic        busy;
  logic        line_done;
  attr_state_t state_dbg;

  logic [7:0]  rom [128];
  logic [1:0]  exp_q[$];
  logic [1:0]  got_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int rd_cnt = 0;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) rom_dout <= rom[rom_addr];

  attr_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .tile_row   (tile_row),
    .nt_sel     (nt_sel),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .pal_data   (pal_data),
    .pal_valid  (pal_valid),
    .pal_ready  (pal_ready),
    .busy       (busy),
    .line_done  (line_done),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_pal(input logic [4:0] row, input logic nt, input int col);
    logic [6:0] a;
    logic [7:0] b;
    int sh;
    a  = {nt, row[4:2], 3'(col >> 2)};
    b  = rom[a];
    sh = 2 * (int'(row[1]) * 2 + ((col >> 1) & 1));
    return 2'((b >> sh) & 8'h03);
  endfunction

  task automatic expect_line(input logic [4:0] row, input logic nt);
    for (int c = 0; c < 32; c++) exp_q.push_back(model_pal(row, nt, c));
  endtask

  // driver: one-cycle line_start pulse; rec=1 restarts the per-line counters
  task automatic pulse_start(input logic [4:0] row, input logic nt, input bit rec);
    @(posedge clk); #1;
    if (rec) begin
      pop_cnt = 0; done_cnt = 0; rd_cnt = 0;
      got_q.delete();
    end
    tile_row = row; nt_sel = nt; line_start = 1'b1;
    @(posedge clk); #1;
    if (rec) start_cyc = cyc;
    line_start = 1'b0;
  endtask

  task automatic wait_line_end();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_cnt != 0 && !busy && !pal_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("line_end_timeout", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic line_checks(input bit chk_lat);
    int lat;
    check("queue_drained", exp_q.size(), 0);
    check("pop_count", pop_cnt, 32);
    check("line_done_count", done_cnt, 1);
    check("rom_reads", rd_cnt, READS_PER_LINE);
    if (chk_lat) begin
      lat = done_cyc - start_cyc;
      check("latency_in_range", 32'(lat >= LAT_LO && lat <= LAT_HI), 32'd1);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst) begin
      if (pal_valid && pal_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pal_data", 32'(pal_data), 32'(e));
        end
        got_q.push_back(pal_data);
        pop_cnt++;
      end
      if (line_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (state_dbg == WAIT) rd_cnt++;
    end
  end

  initial begin
    logic [1:0] hand2 [4];
    hand2 = '{2'b00, 2'b00, 2'b11, 2'b11};
    rst = 1'b1; line_start = 1'b0; tile_row = '0; nt_sel = 1'b0; pal_ready = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = 8'(i * 29 + 91);
    rom[0] = 8'h15;
    rom[1] = 8'h05;
    rom[7'h40] = 8'hC6;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_pal_valid", 32'(pal_valid), 32'd0);
    check("rst_pal_data", 32'(pal_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk); #1 rst = 1'b0;

    // basic line, row 0, name table 0
    expect_line(5'd0, 1'b0);
    pulse_start(5'd0, 1'b0, 1'b1);
    wait_line_end();
    line_checks(1'b1);
    for (int c = 0; c < 8; c++) check("t1_hand_pal", 32'(got_q[c]), 32'd1);

    // row 2, name table 1: address sequence and upper quadrants
    expect_line(5'd2, 1'b1);
    pulse_start(5'd2, 1'b1, 1'b1);
    @(negedge clk);
    check("t2_addr_col0", 32'(rom_addr), 32'h40);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("t2_addr_col4", 32'(rom_addr), 32'h41);
    wait_line_end();
    line_checks(1'b1);
    for (int c = 0; c < 4; c++) check("t2_hand_pal", 32'(got_q[c]), 32'(hand2[c]));

    // consumer stalled for a whole line, then released
    pal_ready = 1'b0;
    expect_line(5'd9, 1'b0);
    pulse_start(5'd9, 1'b0, 1'b1);
    repeat (60) @(posedge clk);
    #1;
    check("t3_stall_state", 32'(state_dbg), 32'(ISSUE));
    check("t3_stall_busy", 32'(busy), 32'd1);
    check("t3_stall_valid", 32'(pal_valid), 32'd1);
    check("t3_stall_reads", rd_cnt, STALL_READS);
    check("t3_stall_no_done", done_cnt, 0);
    pal_ready = 1'b1;
    wait_line_end();
    line_checks(1'b0);

    // second line_start while busy is ignored
    expect_line(5'd21, 1'b1);
    pulse_start(5'd21, 1'b1, 1'b1);
    repeat (9) @(posedge clk);
    pulse_start(5'd3, 1'b0, 1'b0);
    wait_line_end();
    line_checks(1'b1);

    // async reset mid-line with entries waiting in the FIFO
    expect_line(5'd5, 1'b0);
    pulse_start(5'd5, 1'b0, 1'b1);
    repeat (21) @(posedge clk);
    #1 pal_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_pops_before_rst", pop_cnt, POPS_BEFORE_RST);
    check("t5_valid_before_rst", 32'(pal_valid), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t5_rst_pal_valid", 32'(pal_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_rom_addr", 32'(rom_addr), 32'd0);
    check("t5_rst_pal_data", 32'(pal_data), 32'd0);
    @(posedge clk); #1 rst = 1'b0; pal_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_line_done", done_cnt, 0);
    check("t5_idle_after_rst", 32'(state_dbg), 32'(IDLE));

    // fresh line after the abort
    expect_line(5'd13, 1'b1);
    pulse_start(5'd13, 1'b1, 1'b1);
    wait_line_end();
    line_checks(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
